// File: rtl/amm_transmitter_pkg.sv
// Shared types and helpers for the Avalon-MM transmitter and its compare path.
package amm_transmitter_pkg;

    localparam int ADDR_W      = 32;
    localparam int AMM_ADDR_W  = ADDR_W;
    localparam int AMM_DATA_W  = 64;
    localparam int DATA_B_W    = AMM_DATA_W / 8;
    localparam int ADDR_B_W    = $clog2(DATA_B_W);
    localparam int AMM_BURST_W = 8;
    localparam int WORDS_W     = AMM_BURST_W - 1;
    localparam string ADDR_TYPE = "BYTE";

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, STOPPED} state_t;
    typedef enum logic {WRITE = 1'b0, READ = 1'b1} op_t;
    typedef enum logic {FIXED = 1'b0, RND_DATA = 1'b1} data_mode_t;

    typedef struct packed {
        op_t                 op;
        logic [ADDR_W-1:0]   start_addr;
        logic [WORDS_W-1:0]  words_count;
        logic [ADDR_B_W-1:0] start_off;
        logic [ADDR_B_W-1:0] end_off;
        data_mode_t          data_mode;
        logic [7:0]          data_ptrn;
    } trans_struct_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   start_addr;
        logic [WORDS_W-1:0]  words_count;
        logic [ADDR_B_W-1:0] start_off;
        logic [ADDR_B_W-1:0] end_off;
        data_mode_t          data_mode;
        logic [7:0]          data_ptrn;
    } cmp_struct_t;

    function automatic cmp_struct_t to_cmp(input trans_struct_t t);
        cmp_struct_t c;
        c.start_addr  = t.start_addr;
        c.words_count = t.words_count;
        c.start_off   = t.start_off;
        c.end_off     = t.end_off;
        c.data_mode   = t.data_mode;
        c.data_ptrn   = t.data_ptrn;
        return c;
    endfunction

    // First beat masks bytes below start_off, last beat masks bytes above end_off.
    function automatic logic [DATA_B_W-1:0] byteenable_ptrn(input logic first,
                                                            input logic [ADDR_B_W-1:0] start_off,
                                                            input logic last,
                                                            input logic [ADDR_B_W-1:0] end_off);
        logic [DATA_B_W-1:0] be;
        be = '1;
        if (first) be &= {DATA_B_W{1'b1}} << start_off;
        if (last)  be &= {DATA_B_W{1'b1}} >> (ADDR_B_W'(DATA_B_W - 1) - end_off);
        return be;
    endfunction

    function automatic logic [AMM_ADDR_W-1:0] amm_address(input logic [ADDR_W-1:0] a);
        if (ADDR_TYPE == "BYTE") return {a[ADDR_W-1:ADDR_B_W], {ADDR_B_W{1'b0}}};
        else                     return a;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] p);
        return {p[6:0], p[6] ^ p[1] ^ p[0]};
    endfunction

endpackage

// File: rtl/amm_transmitter_if.sv
// Descriptor handshake, Avalon-MM master bus and compare push for amm_transmitter.
interface amm_transmitter_if;
    import amm_transmitter_pkg::*;

    logic                   trans_valid_i;
    logic                   trans_ready_o;
    trans_struct_t          trans_struct_i;
    logic [AMM_ADDR_W-1:0]  address_o;
    logic                   read_o;
    logic                   write_o;
    logic [AMM_DATA_W-1:0]  writedata_o;
    logic [DATA_B_W-1:0]    byteenable_o;
    logic [AMM_BURST_W-1:0] burstcount_o;
    logic                   waitrequest_i;
    logic                   readdatavalid_i;
    logic                   cmp_en_o;
    cmp_struct_t            cmp_struct_o;

    modport master (
        input  trans_valid_i, trans_struct_i, waitrequest_i, readdatavalid_i,
        output trans_ready_o, address_o, read_o, write_o, writedata_o,
               byteenable_o, burstcount_o, cmp_en_o, cmp_struct_o
    );

    modport slave (
        output trans_valid_i, trans_struct_i, waitrequest_i, readdatavalid_i,
        input  trans_ready_o, address_o, read_o, write_o, writedata_o,
               byteenable_o, burstcount_o, cmp_en_o, cmp_struct_o
    );

endinterface

// File: rtl/amm_transmitter_data_gen.sv
// 8-bit pattern LFSR with load/advance, replicated across the data bus; shared with the compare path.
module amm_transmitter_data_gen
    import amm_transmitter_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [7:0]            seed_i,
    output logic [AMM_DATA_W-1:0] data_o
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i)         lfsr_d = seed_i;
        else if (advance_i) lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= '0;
        else       lfsr_q <= lfsr_d;
    end

    assign data_o = {DATA_B_W{lfsr_q}};

endmodule

// File: rtl/amm_transmitter.sv
// Avalon-MM burst master: write bursts with generated data, throttled reads pushed to compare.
// Optional statistics counters are enabled by defining AMM_TRANSMITTER_STAT_EN.
module amm_transmitter
    import amm_transmitter_pkg::*;
#(
    parameter int MAX_PEND_WORDS = 16,
    parameter int PEND_W         = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_test_i,
    input  logic              stop_i,
    amm_transmitter_if.master bus,
    output logic              busy_o
`ifdef AMM_TRANSMITTER_STAT_EN
    ,
    output logic [31:0]       wr_cnt_o,
    output logic [31:0]       rd_cnt_o
`endif
);

    state_t                 state_q;
    cmp_struct_t            desc_q, cmp_q;
    logic [WORDS_W-1:0]     beat_q;
    logic [PEND_W-1:0]      pend_q, pend_d;
    logic                   stop_q, stop_d;
    logic                   ready_q, write_q, read_q, cmp_en_q, busy_q;
    logic [DATA_B_W-1:0]    be_q;
    logic [AMM_ADDR_W-1:0]  addr_q;
    logic [AMM_BURST_W-1:0] burst_q, burst_nxt;
    logic [AMM_DATA_W-1:0]  wdata;
    logic                   hs, wr_beat, wr_last, rd_acc, ctl_idle, idle_next;

    function automatic logic fits(input logic [PEND_W-1:0] p, input logic [AMM_BURST_W-1:0] b);
        return (32'(p) + 32'(b)) <= 32'(MAX_PEND_WORDS);
    endfunction

    assign hs        = bus.trans_valid_i && ready_q;
    assign burst_nxt = AMM_BURST_W'(bus.trans_struct_i.words_count) + AMM_BURST_W'(1);
    assign wr_beat   = (state_q == WR_BURST) && !bus.waitrequest_i;
    assign wr_last   = (beat_q == '0);
    assign rd_acc    = (state_q == RD_CMD) && read_q && !bus.waitrequest_i;
    assign ctl_idle  = (state_q == IDLE) || (state_q == STOPPED);

    // start_test only acts between transactions; a readdatavalid at zero is dropped.
    always_comb begin
        stop_d = stop_q;
        if (start_test_i && ctl_idle) stop_d = 1'b0;
        if (stop_i)                   stop_d = 1'b1;

        pend_d = pend_q;
        if (start_test_i && ctl_idle) begin
            pend_d = '0;
        end else begin
            if (rd_acc)                                 pend_d = pend_d + PEND_W'(burst_q);
            if (bus.readdatavalid_i && pend_q != '0)    pend_d = pend_d - PEND_W'(1);
        end

        idle_next = 1'b0;
        case (state_q)
            IDLE:     idle_next = !hs;
            WR_BURST: idle_next = wr_beat && wr_last && !stop_d;
            RD_CMD:   idle_next = rd_acc && !stop_d;
            STOPPED:  idle_next = start_test_i;
            default:  idle_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            desc_q   <= '0;
            cmp_q    <= '0;
            beat_q   <= '0;
            pend_q   <= '0;
            stop_q   <= 1'b0;
            ready_q  <= 1'b0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            cmp_en_q <= 1'b0;
            busy_q   <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            burst_q  <= '0;
        end else begin
            stop_q   <= stop_d;
            pend_q   <= pend_d;
            cmp_en_q <= 1'b0;
            ready_q  <= idle_next && !stop_d;
            busy_q   <= !idle_next || (pend_d != '0);
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        desc_q  <= to_cmp(bus.trans_struct_i);
                        addr_q  <= amm_address(bus.trans_struct_i.start_addr);
                        burst_q <= burst_nxt;
                        beat_q  <= bus.trans_struct_i.words_count;
                        if (bus.trans_struct_i.op == WRITE) begin
                            state_q <= WR_BURST;
                            write_q <= 1'b1;
                            be_q    <= byteenable_ptrn(1'b1, bus.trans_struct_i.start_off,
                                                       bus.trans_struct_i.words_count == '0,
                                                       bus.trans_struct_i.end_off);
                        end else begin
                            state_q <= RD_CMD;
                            read_q  <= fits(pend_d, burst_nxt);
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_beat) begin
                        if (wr_last) begin
                            write_q <= 1'b0;
                            be_q    <= '0;
                            state_q <= stop_d ? STOPPED : IDLE;
                        end else begin
                            beat_q <= beat_q - WORDS_W'(1);
                            be_q   <= byteenable_ptrn(1'b0, desc_q.start_off,
                                                      beat_q == WORDS_W'(1), desc_q.end_off);
                        end
                    end
                end
                RD_CMD: begin
                    if (rd_acc) begin
                        read_q   <= 1'b0;
                        cmp_en_q <= 1'b1;
                        cmp_q    <= desc_q;
                        state_q  <= stop_d ? STOPPED : IDLE;
                    end else begin
                        read_q <= fits(pend_d, burst_q);
                    end
                end
                STOPPED: begin
                    if (start_test_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    amm_transmitter_data_gen u_data_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (hs),
        .advance_i (wr_beat && desc_q.data_mode == RND_DATA),
        .seed_i    (bus.trans_struct_i.data_ptrn),
        .data_o    (wdata)
    );

    assign bus.trans_ready_o = ready_q;
    assign bus.address_o     = addr_q;
    assign bus.read_o        = read_q;
    assign bus.write_o       = write_q;
    assign bus.writedata_o   = wdata;
    assign bus.byteenable_o  = be_q;
    assign bus.burstcount_o  = burst_q;
    assign bus.cmp_en_o      = cmp_en_q;
    assign bus.cmp_struct_o  = cmp_q;
    assign busy_o            = busy_q;

`ifdef AMM_TRANSMITTER_STAT_EN
    logic [31:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_test_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (hs && bus.trans_struct_i.op == WRITE && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
            if (rd_acc && rd_cnt_q != '1)                               rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_amm_transmitter.sv
// Directed self-checking bench for amm_transmitter.
module tb_amm_transmitter;
    import amm_transmitter_pkg::*;

    logic clk = 1'b0;
    logic rst, start_test, stop, busy;
    int   total = 0;
    int   bad   = 0;

    amm_transmitter_if bus ();

`ifdef AMM_TRANSMITTER_STAT_EN
    logic [31:0] wr_cnt, rd_cnt;
`endif

    amm_transmitter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_test_i (start_test),
        .stop_i       (stop),
        .bus          (bus),
        .busy_o       (busy)
`ifdef AMM_TRANSMITTER_STAT_EN
        ,
        .wr_cnt_o     (wr_cnt),
        .rd_cnt_o     (rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic trans_struct_t mk(input op_t op, input logic [ADDR_W-1:0] a,
                                         input logic [WORDS_W-1:0] wc,
                                         input logic [ADDR_B_W-1:0] so, input logic [ADDR_B_W-1:0] eo,
                                         input data_mode_t m, input logic [7:0] p);
        trans_struct_t t;
        t.op = op; t.start_addr = a; t.words_count = wc;
        t.start_off = so; t.end_off = eo; t.data_mode = m; t.data_ptrn = p;
        return t;
    endfunction

    // Waits (bounded) for ready at a falling edge, presents the descriptor for one edge.
    task automatic send(input trans_struct_t t);
        int n;
        n = 0;
        while (bus.trans_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.trans_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: ready=%b required 1", bus.trans_ready_o);
        end
        bus.trans_valid_i  = 1'b1;
        bus.trans_struct_i = t;
        @(negedge clk);
        bus.trans_valid_i  = 1'b0;
    endtask

    task automatic pulse_start();
        start_test = 1'b1;
        @(negedge clk);
        start_test = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.trans_ready_o, bus.write_o, bus.read_o, bus.cmp_en_o, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl: rdy/wr/rd/cmp/busy=%b required 00000",
                     {bus.trans_ready_o, bus.write_o, bus.read_o, bus.cmp_en_o, busy});
        end
        total++;
        if ({bus.address_o, bus.burstcount_o, bus.byteenable_o, bus.writedata_o} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%h bc=%h be=%h wd=%h required all 0",
                     bus.address_o, bus.burstcount_o, bus.byteenable_o, bus.writedata_o);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.trans_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: ready=%b required 1", bus.trans_ready_o);
        end
    endtask

    task automatic test_write_fixed();
        logic [7:0] exp_be [4];
        exp_be = '{8'hFC, 8'hFF, 8'hFF, 8'h3F};
        send(mk(WRITE, 32'h100, 7'd3, 3'd2, 3'd5, FIXED, 8'hA5));
        for (int b = 0; b < 4; b++) begin
            total++;
            if ({bus.write_o, bus.trans_ready_o, bus.address_o, bus.burstcount_o, bus.byteenable_o, bus.writedata_o}
                !== {1'b1, 1'b0, 32'h100, 8'd4, exp_be[b], {8{8'hA5}}}) begin
                bad++;
                $display("FAIL wr_fixed beat%0d: wr=%b rdy=%b addr=%h bc=%0d be=%h wd=%h required 1 0 00000100 4 %h a5a5a5a5a5a5a5a5",
                         b, bus.write_o, bus.trans_ready_o, bus.address_o, bus.burstcount_o,
                         bus.byteenable_o, bus.writedata_o, exp_be[b]);
            end
            @(negedge clk);
        end
        total++;
        if ({bus.write_o, busy} !== 2'b00) begin
            bad++;
            $display("FAIL wr_fixed_end: write/busy=%b required 00", {bus.write_o, busy});
        end
    endtask

    task automatic test_single_beat();
        send(mk(WRITE, 32'h208, 7'd0, 3'd2, 3'd5, FIXED, 8'h11));
        total++;
        if ({bus.write_o, bus.burstcount_o, bus.byteenable_o} !== {1'b1, 8'd1, 8'h3C}) begin
            bad++;
            $display("FAIL single_beat: wr=%b bc=%0d be=%h required 1 1 3c",
                     bus.write_o, bus.burstcount_o, bus.byteenable_o);
        end
        @(negedge clk);
        total++;
        if (bus.write_o !== 1'b0) begin
            bad++;
            $display("FAIL single_beat_end: write=%b required 0", bus.write_o);
        end
    endtask

    task automatic test_write_rnd();
        logic [7:0] exp_p [5];
        logic       stall [5];
        exp_p = '{8'h01, 8'h03, 8'h03, 8'h03, 8'h06};
        stall = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        send(mk(WRITE, 32'h103, 7'd2, 3'd0, 3'd7, RND_DATA, 8'h01));
        for (int c = 0; c < 5; c++) begin
            bus.waitrequest_i = stall[c];
            total++;
            if ({bus.write_o, bus.address_o, bus.burstcount_o, bus.byteenable_o, bus.writedata_o}
                !== {1'b1, 32'h100, 8'd3, 8'hFF, {8{exp_p[c]}}}) begin
                bad++;
                $display("FAIL wr_rnd cyc%0d: wr=%b addr=%h bc=%0d be=%h wd=%h required 1 00000100 3 ff pattern %h",
                         c, bus.write_o, bus.address_o, bus.burstcount_o, bus.byteenable_o,
                         bus.writedata_o, exp_p[c]);
            end
            @(negedge clk);
        end
        bus.waitrequest_i = 1'b0;
        total++;
        if (bus.write_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_rnd_end: write=%b required 0", bus.write_o);
        end
    endtask

    task automatic test_read();
        cmp_struct_t exp;
        exp.start_addr = 32'h2000; exp.words_count = 7'd7; exp.start_off = 3'd1;
        exp.end_off = 3'd6; exp.data_mode = FIXED; exp.data_ptrn = 8'h5A;
        send(mk(READ, 32'h2000, 7'd7, 3'd1, 3'd6, FIXED, 8'h5A));
        total++;
        if ({bus.read_o, bus.write_o, bus.cmp_en_o, bus.address_o, bus.burstcount_o}
            !== {1'b1, 1'b0, 1'b0, 32'h2000, 8'd8}) begin
            bad++;
            $display("FAIL read_cmd: rd=%b wr=%b cmp=%b addr=%h bc=%0d required 1 0 0 00002000 8",
                     bus.read_o, bus.write_o, bus.cmp_en_o, bus.address_o, bus.burstcount_o);
        end
        @(negedge clk);
        total++;
        if ({bus.read_o, bus.cmp_en_o, bus.cmp_struct_o} !== {1'b0, 1'b1, exp}) begin
            bad++;
            $display("FAIL read_cmp: rd=%b cmp_en=%b cmp=%h required 0 1 %h",
                     bus.read_o, bus.cmp_en_o, bus.cmp_struct_o, exp);
        end
        @(negedge clk);
        total++;
        if ({bus.cmp_en_o, busy} !== 2'b01) begin
            bad++;
            $display("FAIL read_pend: cmp_en/busy=%b required 01", {bus.cmp_en_o, busy});
        end
        pulse_start();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL read_clear: busy=%b required 0", busy);
        end
    endtask

    task automatic test_rdv_underflow();
        bus.readdatavalid_i = 1'b1;
        @(negedge clk);
        bus.readdatavalid_i = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rdv_at_zero: busy=%b required 0", busy);
        end
        send(mk(READ, 32'h3000, 7'd15, 3'd0, 3'd7, FIXED, 8'h00));
        total++;
        if ({bus.read_o, bus.burstcount_o} !== {1'b1, 8'd16}) begin
            bad++;
            $display("FAIL read_full_window: rd=%b bc=%0d required 1 16", bus.read_o, bus.burstcount_o);
        end
        @(negedge clk);
        pulse_start();
    endtask

    task automatic test_throttle();
        send(mk(READ, 32'h4000, 7'd7, 3'd0, 3'd7, FIXED, 8'h00));
        send(mk(READ, 32'h4040, 7'd7, 3'd0, 3'd7, FIXED, 8'h00));
        total++;
        if (bus.read_o !== 1'b1) begin
            bad++;
            $display("FAIL throttle_second: read=%b required 1", bus.read_o);
        end
        send(mk(READ, 32'h4080, 7'd7, 3'd0, 3'd7, FIXED, 8'h00));
        repeat (3) @(negedge clk);
        total++;
        if (bus.read_o !== 1'b0) begin
            bad++;
            $display("FAIL throttle_hold: read=%b required 0", bus.read_o);
        end
        for (int i = 0; i < 8; i++) begin
            bus.readdatavalid_i = 1'b1;
            @(negedge clk);
            total++;
            if (bus.read_o !== (i == 7)) begin
                bad++;
                $display("FAIL throttle_rdv%0d: read=%b required %b", i + 1, bus.read_o, (i == 7));
            end
        end
        bus.readdatavalid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.read_o, bus.cmp_en_o, bus.cmp_struct_o.start_addr} !== {1'b0, 1'b1, 32'h4080}) begin
            bad++;
            $display("FAIL throttle_accept: rd=%b cmp_en=%b addr=%h required 0 1 00004080",
                     bus.read_o, bus.cmp_en_o, bus.cmp_struct_o.start_addr);
        end
        pulse_start();
    endtask

    task automatic test_stop();
        send(mk(WRITE, 32'h40, 7'd3, 3'd0, 3'd7, FIXED, 8'h3C));
        stop = 1'b1;
        for (int b = 0; b < 4; b++) begin
            total++;
            if ({bus.write_o, bus.trans_ready_o} !== 2'b10) begin
                bad++;
                $display("FAIL stop_beat%0d: write/ready=%b required 10", b, {bus.write_o, bus.trans_ready_o});
            end
            @(negedge clk);
            stop = 1'b0;
        end
        repeat (3) @(negedge clk);
        total++;
        if ({bus.write_o, bus.trans_ready_o, busy} !== 3'b001) begin
            bad++;
            $display("FAIL stopped: write/ready/busy=%b required 001", {bus.write_o, bus.trans_ready_o, busy});
        end
        pulse_start();
        total++;
        if ({bus.trans_ready_o, busy} !== 2'b10) begin
            bad++;
            $display("FAIL stop_restart: ready/busy=%b required 10", {bus.trans_ready_o, busy});
        end
    endtask

    task automatic test_reset_mid_write();
        send(mk(WRITE, 32'h80, 7'd3, 3'd0, 3'd7, FIXED, 8'h77));
        total++;
        if ({bus.write_o, busy} !== 2'b11) begin
            bad++;
            $display("FAIL midrst_pre: write/busy=%b required 11", {bus.write_o, busy});
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.write_o, busy} !== 2'b00) begin
            bad++;
            $display("FAIL midrst_post: write/busy=%b required 00", {bus.write_o, busy});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.trans_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready: ready=%b required 1", bus.trans_ready_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_test = 1'b0;
        stop = 1'b0;
        bus.trans_valid_i   = 1'b0;
        bus.trans_struct_i  = '0;
        bus.waitrequest_i   = 1'b0;
        bus.readdatavalid_i = 1'b0;
        test_reset();
        test_write_fixed();
        test_single_beat();
        test_write_rnd();
        test_read();
        test_rdv_underflow();
        test_throttle();
        test_stop();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
